hazard_sb: RTL and testbench
============================

# hazard_sb

Parametrised hazard, forwarding and scoreboard unit for the next-generation five-stage RISC-V pipeline. It sits beside the ID/EX pipeline register and produces per-operand forward selects, an ID stall, an ID flush and an issue strobe. It extends the plain hazard/forwarding unit with three additions: a scoreboard for one outstanding multi-cycle (long-latency) operation, a load-use interlock with two-stage load data, and a saturating stall-cycle performance counter.

## Interface
- `NREG`, 32: architectural register count.
- `RADDR_W`, 5: register address width; must equal `$clog2(NREG)`.
- `LONG_LAT`, 4: cycles from long-op issue to result write; must be ≥2.
- `PERF_W`, 32: stall counter width.

- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `id_valid`  in  1  ID holds a valid instruction
- `id_rs1`, `id_rs2`  in  RADDR_W  ID source registers
- `id_use_rs1`, `id_use_rs2`  in  1  the source is actually read
- `id_rd`  in  RADDR_W  ID destination
- `id_regwr`  in  1  ID instruction writes `rd`
- `id_is_long`  in  1  ID instruction is a multi-cycle op
- `ex_rd`, `mem_rd`, `wb_rd`  in  RADDR_W  stage destinations
- `ex_regwr`, `mem_regwr`, `wb_regwr`  in  1  stage write enables
- `ex_is_load`, `mem_is_load`  in  1  stage holds a load
- `redirect`  in  1  EX branch/jump taken; kill the ID instruction
- `rs1_fwd`, `rs2_fwd`  out  2  operand select: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB
- `stall`  out  1  hold IF/ID; insert a bubble into ID/EX
- `flush_id`  out  1  kill the ID instruction
- `issue`  out  1  the ID instruction advances this cycle
- `long_busy`  out  1  a long op is outstanding
- `long_wb_valid`  out  1  long-op result writes via the second regfile port this cycle
- `long_wb_rd`  out  RADDR_W  long-op destination
- `stall_cycles`  out  PERF_W  saturating count of cycles with `stall`=1

## Operation
- A source "matches" a stage when: the source is used, it is nonzero, and it equals a stage `rd` whose `regwr`=1. x0 never causes a hazard and is never forwarded.
- **Forward priority:** EX > MEM > WB > regfile. The youngest producer wins.
- **Load-use stall:**
  - A match on EX with `ex_is_load` stalls.
  - A match on MEM with `mem_is_load` stalls. Load data is first forwardable from WB.
- **Scoreboard stall.** While `long_busy`=1, stall if any of the following holds:
  - a used source equals `long_wb_rd`;
  - `id_regwr` is set and `id_rd` equals `long_wb_rd` (WAW);
  - `id_is_long` is set.
- `stall` is asserted only when `id_valid`=1 and `redirect`=0.
- `flush_id` = `redirect`. Redirect has priority over stall.
- `issue` = `id_valid` & !`stall` & !`redirect`.
- **Long-op issue:** when `issue` and `id_is_long` are both set:
  - latch `id_rd` into `long_wb_rd`;
  - load the down-counter with `LONG_LAT`-1;
  - set `long_busy`.
- **Long-op tracker FSM** (counter width `$clog2(LONG_LAT)`):
  - IDLE → BUSY on long issue.
  - BUSY decrements each cycle. At 0, assert `long_wb_valid` for one cycle, then return to IDLE.
  - A long op already issued is not cancelled by `redirect`.
- **`stall_cycles`:** increments each cycle in which `stall`=1. It holds at all-ones and never wraps.
- **Reset values:** tracker IDLE, counter 0, `long_wb_rd`=0, `long_busy`=0, `long_wb_valid`=0, `stall_cycles`=0.
- Reset asserted mid-long-op drops the pending op immediately, with no `long_wb_valid` pulse.

## Timing
- `rs*_fwd`, `stall`, `flush_id` and `issue` are combinational from the same-cycle inputs.
- Long op issued in cycle T:
  - `long_busy`=1 in cycles T+1 … T+`LONG_LAT`;
  - `long_wb_valid`=1 in cycle T+`LONG_LAT` only;
  - a dependent instruction or another long op issues no earlier than T+`LONG_LAT`+1, reading the regfile. The regfile is write-before-read.
- Load in EX at cycle T with a dependent in ID: stalls in T and T+1, issues in T+2 with `rs_fwd`=3.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding operates as described above.
- `HAZARD_FWD_EN` undefined:
  - `rs1_fwd` and `rs2_fwd` are constant 0;
  - any match on EX, MEM or WB stalls;
  - scoreboard and counter behaviour are unchanged.

## Structure
- **Package `hazard_pkg`:**
  - `fwd_sel_t` enum: `FWD_RF`=0, `FWD_EX`=1, `FWD_MEM`=2, `FWD_WB`=3;
  - tracker state enum: `LT_IDLE`, `LT_BUSY`.
- **Sub-module `long_tracker`:**
  - contains the FSM, down-counter and `long_wb_rd` register;
  - takes `issue_long`/`rd` in and gives `busy`/`wb_valid`/`wb_rd` out.
- Match logic, priority encoding and the perf counter stay in the top.

## Test plan
- ID `rs1`=5, EX `rd`=5 with `regwr`=1 and not a load → `rs1_fwd`=1, `stall`=0, `issue`=1. With MEM and WB also `rd`=5 → still 1.
- Load to x7 in EX, ID reads x7 → `stall`=1 for two cycles, then `rs2_fwd`=3, `issue`=1. `stall_cycles` increases by 2.
- `LONG_LAT`=4, long op to x9 issued at T, ID reads x9 at T+1 → `stall` through T+4, `long_wb_valid` only at T+4, `issue` at T+5.
- `redirect`=1 while a load-use stall condition holds → `flush_id`=1, `stall`=0, `issue`=0.
- EX `rd`=0 with `regwr`=1, ID `rs1`=0 → `rs1_fwd`=0, `stall`=0.
- Force `stall_cycles` to all-ones minus 1, then stall 3 cycles → value holds at all-ones. Assert `rst` mid-long-op → `long_busy`=0 immediately, with no `long_wb_valid` pulse.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding/scoreboard unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        LT_IDLE = 1'b0,
        LT_BUSY = 1'b1
    } lt_state_t;

endpackage

// File: rtl/long_tracker.sv
// Tracks one outstanding long-latency op: down-counter, destination register
// and the one-cycle writeback strobe on the second regfile port.
module long_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned RADDR_W  = 5
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_long,
    input  logic [RADDR_W-1:0] rd,
    output logic               busy,
    output logic               wb_valid,
    output logic [RADDR_W-1:0] wb_rd
);

    localparam int unsigned CNT_W = $clog2(LONG_LAT);

    if (LONG_LAT < 2) begin : g_bad_lat
        $error("long_tracker: LONG_LAT must be at least 2");
    end

    lt_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RADDR_W-1:0] rd_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LT_IDLE;
            cnt   <= '0;
            wb_rd <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wb_rd <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rd_nxt    = wb_rd;
        case (state)
            LT_IDLE: begin
                if (issue_long) begin
                    state_nxt = LT_BUSY;
                    cnt_nxt   = CNT_W'(LONG_LAT - 1);
                    rd_nxt    = rd;
                end
            end
            LT_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = LT_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = LT_IDLE;
        endcase
    end

    // Writeback lands in the last busy cycle, when the counter has drained.
    always_comb begin
        busy     = (state == LT_BUSY);
        wb_valid = (state == LT_BUSY) && (cnt == '0);
    end

endmodule

// File: rtl/hazard_sb.sv
// Hazard detection, operand forwarding and long-op scoreboard beside ID/EX.
// Optional forwarding is enabled by defining HAZARD_FWD_EN; otherwise every
// producer match stalls.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned RADDR_W  = 5,
    parameter int unsigned LONG_LAT = 4,
    parameter int unsigned PERF_W   = 32
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_regwr,
    input  logic               id_is_long,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               ex_regwr,
    input  logic               mem_regwr,
    input  logic               wb_regwr,
    input  logic               ex_is_load,
    input  logic               mem_is_load,
    input  logic               redirect,
    output logic [1:0]         rs1_fwd,
    output logic [1:0]         rs2_fwd,
    output logic               stall,
    output logic               flush_id,
    output logic               issue,
    output logic               long_busy,
    output logic               long_wb_valid,
    output logic [RADDR_W-1:0] long_wb_rd,
    output logic [PERF_W-1:0]  stall_cycles
);

    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    if (RADDR_W != $clog2(NREG)) begin : g_bad_raddr
        $error("hazard_sb: RADDR_W must equal clog2(NREG)");
    end

    // x0 is hardwired zero, so it never matches a producer.
    function automatic logic src_hit(input logic [RADDR_W-1:0] src, input logic used,
                                     input logic [RADDR_W-1:0] dst, input logic wr);
        return used && (src != '0) && (src == dst) && wr;
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic fwd_sel_t fwd_pick(input logic e, input logic m, input logic w);
        if (e) return FWD_EX;
        if (m) return FWD_MEM;
        if (w) return FWD_WB;
        return FWD_RF;
    endfunction
`else
    logic unused_load;
    assign unused_load = ex_is_load ^ mem_is_load;
`endif

    logic ex1, ex2, mem1, mem2, wb1, wb2;
    logic hazard, sb_hit;

    assign ex1  = src_hit(id_rs1, id_use_rs1, ex_rd,  ex_regwr);
    assign ex2  = src_hit(id_rs2, id_use_rs2, ex_rd,  ex_regwr);
    assign mem1 = src_hit(id_rs1, id_use_rs1, mem_rd, mem_regwr);
    assign mem2 = src_hit(id_rs2, id_use_rs2, mem_rd, mem_regwr);
    assign wb1  = src_hit(id_rs1, id_use_rs1, wb_rd,  wb_regwr);
    assign wb2  = src_hit(id_rs2, id_use_rs2, wb_rd,  wb_regwr);

    always_comb begin
        rs1_fwd = 2'(FWD_RF);
        rs2_fwd = 2'(FWD_RF);
        hazard  = 1'b0;
`ifdef HAZARD_FWD_EN
        rs1_fwd = 2'(fwd_pick(ex1, mem1, wb1));
        rs2_fwd = 2'(fwd_pick(ex2, mem2, wb2));
        // Load data is not available until WB.
        hazard  = ((ex1 | ex2) & ex_is_load) | ((mem1 | mem2) & mem_is_load);
`else
        hazard  = ex1 | ex2 | mem1 | mem2 | wb1 | wb2;
`endif
        sb_hit  = long_busy & ((id_use_rs1 & (id_rs1 == long_wb_rd)) |
                               (id_use_rs2 & (id_rs2 == long_wb_rd)) |
                               (id_regwr   & (id_rd  == long_wb_rd)) |
                               id_is_long);
        stall    = id_valid & ~redirect & (hazard | sb_hit);
        flush_id = redirect;
        issue    = id_valid & ~redirect & ~stall;
    end

    long_tracker #(
        .LONG_LAT (LONG_LAT),
        .RADDR_W  (RADDR_W)
    ) u_long_tracker (
        .clk        (clk),
        .rst        (rst),
        .issue_long (issue & id_is_long),
        .rd         (id_rd),
        .busy       (long_busy),
        .wb_valid   (long_wb_valid),
        .wb_rd      (long_wb_rd)
    );

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != PERF_MAX)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sb.sv
// Randomized and directed bench for hazard_sb against a cycle-indexed reference model.
module tb_hazard_sb;

    localparam int unsigned LL   = 4;
    localparam int unsigned PW   = 4;
    localparam int          PMAX = (1 << PW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwr, id_is_long;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
    logic       ex_regwr, mem_regwr, wb_regwr, ex_is_load, mem_is_load, redirect;
    logic [1:0] rs1_fwd, rs2_fwd;
    logic       stall, flush_id, issue, long_busy, long_wb_valid;
    logic [4:0] long_wb_rd;
    logic [PW-1:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    // Reference model state: long op is described by its issue cycle.
    int         cyc = 0;
    int         long_t = -1;
    int         m_perf = 0;
    logic [4:0] m_long_rd = '0;
    logic [1:0] e_f1, e_f2;
    logic       e_stall, e_flush, e_issue, e_busy, e_wbv;

    hazard_sb #(.NREG(32), .RADDR_W(5), .LONG_LAT(LL), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwr(id_regwr), .id_is_long(id_is_long), .ex_rd(ex_rd), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load), .redirect(redirect),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .stall(stall), .flush_id(flush_id),
        .issue(issue), .long_busy(long_busy), .long_wb_valid(long_wb_valid),
        .long_wb_rd(long_wb_rd), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit hit(logic [4:0] rs, logic u, logic [4:0] rd, logic we);
        return u && rs != 5'd0 && rs == rd && we;
    endfunction

    function automatic logic [1:0] pick(bit e, bit m, bit w);
        if (e) return 2'd1;
        if (m) return 2'd2;
        if (w) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_eval();
        bit e1, e2, m1, m2, w1, w2, hz, sb;
        e1 = hit(id_rs1, id_use_rs1, ex_rd, ex_regwr);
        e2 = hit(id_rs2, id_use_rs2, ex_rd, ex_regwr);
        m1 = hit(id_rs1, id_use_rs1, mem_rd, mem_regwr);
        m2 = hit(id_rs2, id_use_rs2, mem_rd, mem_regwr);
        w1 = hit(id_rs1, id_use_rs1, wb_rd, wb_regwr);
        w2 = hit(id_rs2, id_use_rs2, wb_rd, wb_regwr);
        e_busy = long_t >= 0 && cyc > long_t && cyc <= long_t + int'(LL);
        e_wbv  = long_t >= 0 && cyc == long_t + int'(LL);
`ifdef HAZARD_FWD_EN
        e_f1 = pick(e1, m1, w1);
        e_f2 = pick(e2, m2, w2);
        hz = ((e1 || e2) && ex_is_load) || ((m1 || m2) && mem_is_load);
`else
        e_f1 = 2'd0;
        e_f2 = 2'd0;
        hz = e1 || e2 || m1 || m2 || w1 || w2;
`endif
        sb = e_busy && ((id_use_rs1 && id_rs1 == m_long_rd) || (id_use_rs2 && id_rs2 == m_long_rd) ||
                        (id_regwr && id_rd == m_long_rd) || id_is_long);
        e_stall = id_valid && !redirect && (hz || sb);
        e_flush = redirect;
        e_issue = id_valid && !redirect && !e_stall;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!rst) begin
            if (e_stall && m_perf < PMAX) m_perf++;
            if (e_issue && id_is_long) begin
                long_t = cyc;
                m_long_rd = id_rd;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwr = 0; id_is_long = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwr = 0; mem_regwr = 0; wb_regwr = 0; ex_is_load = 0; mem_is_load = 0;
        redirect = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        long_t = -1; m_perf = 0; m_long_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (long_busy !== 1'b0 || long_wb_valid !== 1'b0 || long_wb_rd !== 5'd0 || stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset busy=%b wbv=%b wbrd=%0d perf=%0d exp 0/0/0/0",
                     long_busy, long_wb_valid, long_wb_rd, stall_cycles);
        end
        checks++;
        if (stall !== 1'b0 || issue !== 1'b0 || rs1_fwd !== 2'd0) begin
            failures++;
            $display("FAIL reset_comb stall=%b issue=%b fwd=%0d exp 0/0/0", stall, issue, rs1_fwd);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; id_rd = 1; id_regwr = 1;
        ex_rd = 5; ex_regwr = 1;
        #1 model_eval();
        checks++;
        if (rs1_fwd !== e_f1 || stall !== e_stall || issue !== e_issue) begin
            failures++;
            $display("FAIL fwd_ex fwd=%0d stall=%b issue=%b exp %0d/%b/%b", rs1_fwd, stall, issue, e_f1, e_stall, e_issue);
        end
        mem_rd = 5; mem_regwr = 1; wb_rd = 5; wb_regwr = 1;
        #1 model_eval();
        checks++;
        if (rs1_fwd !== e_f1 || stall !== e_stall) begin
            failures++;
            $display("FAIL fwd_prio_all fwd=%0d stall=%b exp %0d/%b", rs1_fwd, stall, e_f1, e_stall);
        end
        ex_regwr = 0; id_rs2 = 5; id_use_rs2 = 1;
        #1 model_eval();
        checks++;
        if (rs1_fwd !== e_f1 || rs2_fwd !== e_f2) begin
            failures++;
            $display("FAIL fwd_mem fwd1=%0d fwd2=%0d exp %0d/%0d", rs1_fwd, rs2_fwd, e_f1, e_f2);
        end
        mem_regwr = 0;
        #1 model_eval();
        checks++;
        if (rs1_fwd !== e_f1 || rs2_fwd !== e_f2 || stall !== e_stall) begin
            failures++;
            $display("FAIL fwd_wb fwd1=%0d fwd2=%0d stall=%b exp %0d/%0d/%b", rs1_fwd, rs2_fwd, stall, e_f1, e_f2, e_stall);
        end
        tick();
    endtask

    task automatic test_x0();
        clear_inputs();
        id_valid = 1; id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0; ex_regwr = 1; ex_is_load = 1;
        #1 model_eval();
        checks++;
        if (rs1_fwd !== 2'd0 || stall !== 1'b0 || issue !== 1'b1) begin
            failures++;
            $display("FAIL x0 fwd=%0d stall=%b issue=%b exp 0/0/1", rs1_fwd, stall, issue);
        end
        tick();
    endtask

    task automatic test_load_use();
        int p0;
        clear_inputs();
        p0 = m_perf;
        id_valid = 1; id_rs2 = 7; id_use_rs2 = 1;
        ex_rd = 7; ex_regwr = 1; ex_is_load = 1;
        #1 model_eval();
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            failures++;
            $display("FAIL load_ex stall=%b issue=%b exp 1/0", stall, issue);
        end
        tick();
        ex_regwr = 0; ex_is_load = 0; mem_rd = 7; mem_regwr = 1; mem_is_load = 1;
        #1 model_eval();
        checks++;
        if (stall !== 1'b1 || issue !== 1'b0) begin
            failures++;
            $display("FAIL load_mem stall=%b issue=%b exp 1/0", stall, issue);
        end
        tick();
        mem_regwr = 0; mem_is_load = 0; wb_rd = 7; wb_regwr = 1;
        #1 model_eval();
        checks++;
        if (rs2_fwd !== e_f2 || stall !== e_stall || issue !== e_issue) begin
            failures++;
            $display("FAIL load_wb fwd=%0d stall=%b issue=%b exp %0d/%b/%b", rs2_fwd, stall, issue, e_f2, e_stall, e_issue);
        end
        checks++;
        if (int'(stall_cycles) !== p0 + 2 || int'(stall_cycles) !== m_perf) begin
            failures++;
            $display("FAIL load_perf perf=%0d exp %0d", stall_cycles, p0 + 2);
        end
        tick();
    endtask

    task automatic test_redirect();
        clear_inputs();
        id_valid = 1; id_rs1 = 3; id_use_rs1 = 1; ex_rd = 3; ex_regwr = 1; ex_is_load = 1;
        redirect = 1;
        #1 model_eval();
        checks++;
        if (flush_id !== 1'b1 || stall !== 1'b0 || issue !== 1'b0) begin
            failures++;
            $display("FAIL redirect flush=%b stall=%b issue=%b exp 1/0/0", flush_id, stall, issue);
        end
        tick();
    endtask

    task automatic test_long_op();
        clear_inputs();
        id_valid = 1; id_is_long = 1; id_regwr = 1; id_rd = 9;
        #1 model_eval();
        checks++;
        if (issue !== 1'b1) begin
            failures++;
            $display("FAIL long_issue issue=%b exp 1", issue);
        end
        tick();
        id_is_long = 0; id_rd = 10; id_rs1 = 9; id_use_rs1 = 1;
        for (int k = 1; k <= int'(LL) + 1; k++) begin
            #1 model_eval();
            checks++;
            if (stall !== e_stall || issue !== e_issue || long_busy !== e_busy ||
                long_wb_valid !== e_wbv || long_wb_rd !== 5'd9) begin
                failures++;
                $display("FAIL long_t%0d stall=%b issue=%b busy=%b wbv=%b wbrd=%0d exp %b/%b/%b/%b/9",
                         k, stall, issue, long_busy, long_wb_valid, long_wb_rd, e_stall, e_issue, e_busy, e_wbv);
            end
            checks++;
            if (issue !== (k == int'(LL) + 1) || long_wb_valid !== (k == int'(LL))) begin
                failures++;
                $display("FAIL long_timing_t%0d issue=%b wbv=%b", k, issue, long_wb_valid);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_perf_sat();
        clear_inputs();
        id_valid = 1; id_rs1 = 4; id_use_rs1 = 1; ex_rd = 4; ex_regwr = 1; ex_is_load = 1;
        for (int k = 0; k < PMAX + 4; k++) begin
            tick();
            checks++;
            if (int'(stall_cycles) !== m_perf) begin
                failures++;
                $display("FAIL perf_c%0d perf=%0d exp %0d", k, stall_cycles, m_perf);
            end
        end
        checks++;
        if (stall_cycles !== '1) begin
            failures++;
            $display("FAIL perf_sat perf=%0d exp %0d", stall_cycles, PMAX);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_long();
        do_reset();
        id_valid = 1; id_is_long = 1; id_regwr = 1; id_rd = 12;
        tick();
        clear_inputs();
        tick();
        #2 rst = 1;
        long_t = -1; m_perf = 0; m_long_rd = '0;
        #1;
        checks++;
        if (long_busy !== 1'b0 || long_wb_valid !== 1'b0 || long_wb_rd !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid busy=%b wbv=%b wbrd=%0d exp 0/0/0", long_busy, long_wb_valid, long_wb_rd);
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < int'(LL) + 2; k++) begin
            tick();
            checks++;
            if (long_wb_valid !== 1'b0 || long_busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after%0d busy=%b wbv=%b exp 0/0", k, long_busy, long_wb_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_rd       = 5'($urandom_range(0, 3));
            id_regwr    = 1'($urandom);
            id_is_long  = ($urandom_range(0, 5) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            mem_rd      = 5'($urandom_range(0, 3));
            wb_rd       = 5'($urandom_range(0, 3));
            ex_regwr    = 1'($urandom);
            mem_regwr   = 1'($urandom);
            wb_regwr    = 1'($urandom);
            ex_is_load  = ($urandom_range(0, 3) == 0);
            mem_is_load = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            #1 model_eval();
            checks++;
            if (rs1_fwd !== e_f1 || rs2_fwd !== e_f2 || stall !== e_stall || flush_id !== e_flush ||
                issue !== e_issue) begin
                failures++;
                $display("FAIL rand_comb n=%0d fwd=%0d/%0d stall=%b flush=%b issue=%b exp %0d/%0d/%b/%b/%b",
                         n, rs1_fwd, rs2_fwd, stall, flush_id, issue, e_f1, e_f2, e_stall, e_flush, e_issue);
            end
            checks++;
            if (long_busy !== e_busy || long_wb_valid !== e_wbv || long_wb_rd !== m_long_rd ||
                int'(stall_cycles) !== m_perf) begin
                failures++;
                $display("FAIL rand_state n=%0d busy=%b wbv=%b wbrd=%0d perf=%0d exp %b/%b/%0d/%0d",
                         n, long_busy, long_wb_valid, long_wb_rd, stall_cycles, e_busy, e_wbv, m_long_rd, m_perf);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_x0();
        test_load_use();
        test_redirect();
        test_long_op();
        test_perf_sat();
        test_reset_mid_long();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
